// File: rtl/addr_tr_seq.sv
// addr_tr_seq: time-redundant digit-serial unsigned adder.
// Each CHUNK-bit slice is added twice, the second time with the operands
// swapped on the adder ports, and the two results are compared. A mismatched
// slice is recomputed until the per-transaction retry budget runs out. After
// that the check value is committed and err is raised.
// Optional feature macro: FAULT_INJECT_EN adds inj_en/inj_bit, which corrupt
// the first (CALC) computation.
module addr_tr_seq #(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH:0]                   sum,
    output logic                             err,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retries
`ifdef FAULT_INJECT_EN
    ,
    input  logic                             inj_en,
    input  logic [$clog2(CHUNK+1)-1:0]       inj_bit
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int RW     = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [WIDTH:0]      sum_q;
    logic [CHUNK:0]      p_q;
    logic [IDXW-1:0]     idx_q;
    logic [RW-1:0]       retry_q;
    logic                carry_q;
    logic                err_q;

    logic [CHUNK-1:0]    a_chunk, b_chunk;
    logic [CHUNK:0]      calc_res, chk_res, p_next;
    logic                match, commit, last;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Slice selection, both redundant additions and the commit decision
    always_comb begin
        a_chunk  = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_chunk  = b_q[int'(idx_q)*CHUNK +: CHUNK];
        calc_res = add_chunk(a_chunk, b_chunk, carry_q);
        chk_res  = add_chunk(b_chunk, a_chunk, carry_q);
`ifdef FAULT_INJECT_EN
        p_next   = calc_res ^ (inj_en ? ({{CHUNK{1'b0}}, 1'b1} << inj_bit) : '0);
`else
        p_next   = calc_res;
`endif
        match    = (p_q == chk_res);
        // Once the budget is spent, retry_q stays at MAX_RETRY, so every later
        // mismatch in the same transaction commits directly.
        commit   = match || (retry_q == RW'(MAX_RETRY));
        last     = (idx_q == IDXW'(NCHUNK - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    state_d = CHECK;
            CHECK:   state_d = (commit && last) ? DONE : CALC;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, slice commit, carry/index/retry tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            p_q     <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        retry_q <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                CALC: p_q <= p_next;
                CHECK: begin
                    if (commit) begin
                        // On a match P equals S, so S is always the value committed.
                        sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chk_res[CHUNK-1:0];
                        carry_q <= chk_res[CHUNK];
                        if (!match) err_q <= 1'b1;
                        if (last) sum_q[WIDTH] <= chk_res[CHUNK];
                        else      idx_q <= idx_q + IDXW'(1);
                    end else begin
                        retry_q <= retry_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        err       = err_q;
        retries   = retry_q;
    end

endmodule

// File: tb/tb_addr_tr_seq.sv
// Directed bench for addr_tr_seq: an 8-bit default instance plus a
// WIDTH=16 instance. Injection vectors need FAULT_INJECT_EN.
module tb_addr_tr_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // 8-bit instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, err8;
    logic [7:0] a8, b8;
    logic [8:0] sum8;
    logic [1:0] ret8;
    logic       inj_en;
    logic [2:0] inj_bit;

    // 16-bit instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, err16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;
    logic [1:0]  ret16;

    addr_tr_seq u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .err(err8), .retries(ret8)
`ifdef FAULT_INJECT_EN
        , .inj_en(inj_en), .inj_bit(inj_bit)
`endif
    );

    addr_tr_seq #(.WIDTH(16), .CHUNK(4), .MAX_RETRY(3)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .err(err16), .retries(ret16)
`ifdef FAULT_INJECT_EN
        , .inj_en(1'b0), .inj_bit(3'd0)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit transaction. inj_mode: 0 none, 1 first CALC only, 2 every CALC.
    // With preload set, the next operands are presented while stalled in DONE.
    task automatic xact8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [8:0] esum, input logic eerr, input logic [1:0] eret,
                         input int elat, input int stall, input int inj_mode,
                         input logic [2:0] ibit, input logic preload,
                         input logic [7:0] na, input logic [7:0] nb);
        int n;
        n = 0;
        while (!in_ready8 && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_rdy"}, 32'(in_ready8), 32'd1);
        a8 = ta; b8 = tb_; in_valid8 = 1'b1;
        out_ready8 = (stall == 0);
        step();                       // accept edge
        in_valid8 = 1'b0;
        inj_en    = (inj_mode != 0);
        inj_bit   = ibit;
        check_eq({tag, "_busy"}, 32'(in_ready8), 32'd0);
        n = 0;
        while (!out_valid8 && n < 100) begin
            step();
            n++;
            if (inj_mode == 1) inj_en = 1'b0;
        end
        inj_en = 1'b0;
        check_eq({tag, "_lat"}, 32'(n), 32'(elat));
        check_eq({tag, "_ov"},  32'(out_valid8), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum8), 32'(esum));
        check_eq({tag, "_err"}, 32'(err8), 32'(eerr));
        check_eq({tag, "_ret"}, 32'(ret8), 32'(eret));
        for (int i = 0; i < stall; i++) begin
            if (preload && i == 0) begin
                a8 = na; b8 = nb; in_valid8 = 1'b1;
            end
            step();
            check_eq({tag, "_hold_ov"},  32'(out_valid8), 32'd1);
            check_eq({tag, "_hold_sum"}, 32'(sum8), 32'(esum));
            check_eq({tag, "_hold_rdy"}, 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        step();
        check_eq({tag, "_ov_drop"}, 32'(out_valid8), 32'd0);
        out_ready8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        inj_en = 1'b0; inj_bit = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_in_ready",  32'(in_ready8),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid8), 32'd0);
        check_eq("rst_sum",       32'(sum8),       32'd0);
        check_eq("rst_err",       32'(err8),       32'd0);
        check_eq("rst_retries",   32'(ret8),       32'd0);

        // Carry ripple through both slices into the MSB
        xact8("ff01", 8'hFF, 8'h01, 9'h100, 1'b0, 2'd0, 4, 0, 0, 3'd0, 1'b0, 8'h00, 8'h00);

        // Stall in DONE while the next operands wait; then the next one
        xact8("zero", 8'h00, 8'h00, 9'h000, 1'b0, 2'd0, 4, 3, 0, 3'd0, 1'b1, 8'hA5, 8'h5A);
        xact8("a55a", 8'hA5, 8'h5A, 9'h0FF, 1'b0, 2'd0, 4, 0, 0, 3'd0, 1'b0, 8'h00, 8'h00);
        in_valid8 = 1'b0;

`ifdef FAULT_INJECT_EN
        // Single corrupted CALC on slice 0 bit 0: one retry, two extra cycles
        xact8("inj1", 8'h37, 8'h19, 9'h050, 1'b0, 2'd1, 6, 0, 1, 3'd0, 1'b0, 8'h00, 8'h00);
        // Persistent cout corruption: budget exhausted, S committed
        xact8("injc", 8'h0F, 8'h01, 9'h010, 1'b1, 2'd3, 10, 0, 2, 3'd4, 1'b0, 8'h00, 8'h00);
`endif

        // Reset during CHECK of slice 1 discards the transaction
        a8 = 8'h3C; b8 = 8'h4D; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();                       // accept edge -> CALC slice 0
        in_valid8 = 1'b0;
        repeat (3) step();            // CHECK slice 1
        check_eq("mid_busy", 32'(in_ready8), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rdy", 32'(in_ready8), 32'd1);
        check_eq("mid_sum", 32'(sum8),      32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid8) seen++;
            step();
        end
        check_eq("mid_no_ov", 32'(seen), 32'd0);
        out_ready8 = 1'b0;
        xact8("8080", 8'h80, 8'h80, 9'h100, 1'b0, 2'd0, 4, 0, 0, 3'd0, 1'b0, 8'h00, 8'h00);

        // 16-bit instance: four slices, full carry chain
        a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1; out_ready16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 100) begin
            step();
            n++;
        end
        check_eq("w16_lat", 32'(n),      32'd8);
        check_eq("w16_sum", 32'(sum16),  32'h1FFFE);
        check_eq("w16_err", 32'(err16),  32'd0);
        step();
        check_eq("w16_ov_drop", 32'(out_valid16), 32'd0);
        check_eq("w16_rdy",     32'(in_ready16),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
